// File: rtl/btn_pulse_repeat.sv
// Button/switch conditioner: 2-flop sync, per-channel debounce, press pulses with optional
// auto-repeat on btn[4:1] when BTN_REPEAT_EN is defined (btn[0] never repeats).
module btn_pulse_repeat #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_RATE     = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn,
    input  logic [7:0] sw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse,
    output logic [7:0] sw_ok
);

    localparam int unsigned NumIn   = 13;
    localparam int unsigned NumBtn  = 5;
    localparam int unsigned DbWRaw  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DbW     = (DbWRaw < 1) ? 1 : DbWRaw;
    localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES);

    logic [NumIn-1:0]  raw;
    logic [NumIn-1:0]  sync1_q;
    logic [NumIn-1:0]  sync2_q;
    logic [NumIn-1:0]  level_q;
    logic [DbW-1:0]    db_cnt_q [NumIn];
    logic [NumBtn-1:0] btn_rise;
    logic [NumBtn-1:0] btn_fall;
    logic [NumBtn-1:0] pulse_q;

    assign raw = {sw, btn};

    // Synchronisers and debounce: the level flips on the edge where the counter already
    // holds DEBOUNCE_CYCLES, giving DEBOUNCE_CYCLES+2 cycles of total latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            for (int i = 0; i < NumIn; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < NumIn; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbMax) begin
                    db_cnt_q[i] <= '0;
                    level_q[i]  <= ~level_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        btn_rise = '0;
        btn_fall = '0;
        for (int i = 0; i < NumBtn; i++) begin
            if ((sync2_q[i] != level_q[i]) && (db_cnt_q[i] == DbMax)) begin
                btn_rise[i] = ~level_q[i];
                btn_fall[i] = level_q[i];
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int unsigned RptMaxVal = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RptWRaw   = $clog2(RptMaxVal + 1);
    localparam int unsigned RptW      = (RptWRaw < 1) ? 1 : RptWRaw;
    localparam logic [RptW-1:0] DelayLast = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] RateLast  = RptW'(REPEAT_RATE - 1);
    localparam logic [RptW-1:0] RptSat    = '1;

    typedef enum logic [1:0] {StIdle, StHeld, StRepeat} state_t;

    state_t          state_q [NumBtn];
    logic [RptW-1:0] rpt_q   [NumBtn];

    // Release wins over a repeat pulse due on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pulse_q <= '0;
            for (int i = 0; i < NumBtn; i++) begin
                state_q[i] <= StIdle;
                rpt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NumBtn; i++) begin
                pulse_q[i] <= 1'b0;
                if (btn_fall[i]) begin
                    state_q[i] <= StIdle;
                    rpt_q[i]   <= '0;
                end else if (btn_rise[i]) begin
                    state_q[i] <= StHeld;
                    pulse_q[i] <= 1'b1;
                    rpt_q[i]   <= '0;
                end else begin
                    unique case (state_q[i])
                        StIdle: rpt_q[i] <= '0;
                        StHeld: begin
                            if (i != 0) begin
                                if (rpt_q[i] == DelayLast) begin
                                    pulse_q[i] <= 1'b1;
                                    state_q[i] <= StRepeat;
                                    rpt_q[i]   <= '0;
                                end else if (rpt_q[i] != RptSat) begin
                                    rpt_q[i] <= rpt_q[i] + 1'b1;
                                end
                            end
                        end
                        StRepeat: begin
                            if (rpt_q[i] == RateLast) begin
                                pulse_q[i] <= 1'b1;
                                rpt_q[i]   <= '0;
                            end else if (rpt_q[i] != RptSat) begin
                                rpt_q[i] <= rpt_q[i] + 1'b1;
                            end
                        end
                        default: state_q[i] <= StIdle;
                    endcase
                end
            end
        end
    end
`else
    typedef enum logic {StIdle, StHeld} state_t;

    state_t state_q [NumBtn];
    logic   unused_repeat_params;

    assign unused_repeat_params = ^{REPEAT_DELAY, REPEAT_RATE};

    always_ff @(posedge clk) begin
        if (!reset) begin
            pulse_q <= '0;
            for (int i = 0; i < NumBtn; i++) begin
                state_q[i] <= StIdle;
            end
        end else begin
            for (int i = 0; i < NumBtn; i++) begin
                pulse_q[i] <= btn_rise[i];
                if (btn_fall[i]) begin
                    state_q[i] <= StIdle;
                end else if (btn_rise[i]) begin
                    state_q[i] <= StHeld;
                end
            end
        end
    end
`endif

    assign btn_level = level_q[NumBtn-1:0];
    assign sw_ok     = level_q[NumIn-1:NumBtn];
    assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_btn_pulse_repeat.sv
// Directed bench for btn_pulse_repeat with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
// Cycle k means the state just after the k-th edge, edge 0 being the first to sample new inputs.
module tb_btn_pulse_repeat;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn;
    logic [7:0] sw;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;
    logic [7:0] sw_ok;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    btn_pulse_repeat #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .sw       (sw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .sw_ok    (sw_ok)
    );

    // Leaves the bench #1 after an edge with reset released and inputs low.
    task automatic do_reset();
        reset = 1'b0;
        btn   = '0;
        sw    = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        btn   = '1;
        sw    = '1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({btn_level, btn_pulse, sw_ok} !== 18'h0) begin
                failures++;
                $display("FAIL reset k=%0d got lvl=%b pls=%b sw=%h want all 0",
                         k, btn_level, btn_pulse, sw_ok);
            end
        end
        do_reset();
    endtask

    task automatic test_press();
        logic [4:0] el, ep;
        btn = 5'b00010;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            el = (k >= 6) ? 5'b00010 : 5'b0;
            ep = (k == 6) ? 5'b00010 : 5'b0;
            checks++;
            if (btn_level !== el || btn_pulse !== ep || sw_ok !== 8'h0) begin
                failures++;
                $display("FAIL press k=%0d got lvl=%b pls=%b sw=%h want lvl=%b pls=%b sw=00",
                         k, btn_level, btn_pulse, sw_ok, el, ep);
            end
        end
        do_reset();
    endtask

    task automatic test_glitch();
        btn = 5'b00100;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) btn = '0;
            checks++;
            if (btn_level !== 5'b0 || btn_pulse !== 5'b0 || sw_ok !== 8'h0) begin
                failures++;
                $display("FAIL glitch k=%0d got lvl=%b pls=%b sw=%h want all 0",
                         k, btn_level, btn_pulse, sw_ok);
            end
        end
        do_reset();
    endtask

    // Held 60 cycles (sampled high on edges 0..59); level falls at 66 where a repeat would land.
    task automatic test_hold(input int ch, input logic repeats);
        logic [4:0] el, ep;
        logic       hit;
        btn = 5'(1 << ch);
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (k == 59) btn = '0;
            hit = (k == 6);
            if (repeats) hit = hit || (k >= 26 && k <= 58 && ((k - 26) % 8) == 0);
            el = (k >= 6 && k <= 65) ? 5'(1 << ch) : 5'b0;
            ep = hit ? 5'(1 << ch) : 5'b0;
            checks++;
            if (btn_level !== el || btn_pulse !== ep) begin
                failures++;
                $display("FAIL hold ch=%0d k=%0d got lvl=%b pls=%b want lvl=%b pls=%b",
                         ch, k, btn_level, btn_pulse, el, ep);
            end
        end
        do_reset();
    endtask

    // Reset sampled low on edges 11 and 12; button re-debounces from edge 13.
    task automatic test_reset_mid_press();
        logic [4:0] el, ep;
        btn = 5'b01000;
        for (int k = 0; k < 31; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) reset = 1'b0;
            if (k == 12) reset = 1'b1;
            el = ((k >= 6 && k <= 10) || k >= 19) ? 5'b01000 : 5'b0;
            ep = (k == 6 || k == 19) ? 5'b01000 : 5'b0;
            checks++;
            if (btn_level !== el || btn_pulse !== ep || sw_ok !== 8'h0) begin
                failures++;
                $display("FAIL reset_mid k=%0d got lvl=%b pls=%b sw=%h want lvl=%b pls=%b sw=00",
                         k, btn_level, btn_pulse, sw_ok, el, ep);
            end
        end
        do_reset();
    endtask

    task automatic test_switches();
        logic [7:0] es;
        sw = 8'hA5;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            es = (k >= 6) ? 8'hA5 : 8'h00;
            checks++;
            if (sw_ok !== es || btn_pulse !== 5'b0 || btn_level !== 5'b0) begin
                failures++;
                $display("FAIL switches k=%0d got sw=%h pls=%b lvl=%b want sw=%h pls=0 lvl=0",
                         k, sw_ok, btn_pulse, btn_level, es);
            end
        end
        do_reset();
    endtask

    // Simultaneous press, release (level falls at 16), re-press sampled from edge 17.
    task automatic test_back_to_back();
        logic [4:0] el, ep;
        btn = 5'b11110;
        for (int k = 0; k < 31; k++) begin
            @(posedge clk);
            #1;
            if (k == 9)  btn = '0;
            if (k == 16) btn = 5'b11110;
            el = ((k >= 6 && k <= 15) || k >= 23) ? 5'b11110 : 5'b0;
            ep = (k == 6 || k == 23) ? 5'b11110 : 5'b0;
            checks++;
            if (btn_level !== el || btn_pulse !== ep) begin
                failures++;
                $display("FAIL back_to_back k=%0d got lvl=%b pls=%b want lvl=%b pls=%b",
                         k, btn_level, btn_pulse, el, ep);
            end
        end
        do_reset();
    endtask

    initial begin
        reset = 1'b0;
        btn   = '0;
        sw    = '0;
        test_reset();
        test_press();
        test_glitch();
`ifdef BTN_REPEAT_EN
        test_hold(4, 1'b1);
`else
        test_hold(4, 1'b0);
`endif
        test_hold(0, 1'b0);
        test_reset_mid_press();
        test_switches();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_pulse_repeat.md
BTN_PULSE_REPEAT -- requirements
Module: btn_pulse_repeat

Interface
REQ-001 The block SHALL provide parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive cycles a synchronised input must differ from its debounced level before that level flips.
REQ-002 The block SHALL provide parameter REPEAT_DELAY, default 50000000, meaning cycles from a press pulse to the first auto-repeat pulse.
REQ-003 The block SHALL provide parameter REPEAT_RATE, default 10000000, meaning cycles between successive auto-repeat pulses.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 btn  input  5  raw asynchronous buttons; [0]=stamp (centre), [1]=up, [2]=left, [3]=down, [4]=right.
REQ-007 sw  input  8  raw asynchronous switches.
REQ-008 btn_level  output  5  debounced button levels.
REQ-009 btn_pulse  output  5  one-cycle press and repeat pulses to the game controller.
REQ-010 sw_ok  output  8  debounced switch levels.

Function
REQ-011 Each of the 13 inputs SHALL pass through a 2-flop synchroniser before any other logic.
REQ-012 Each input channel SHALL have its own debounce counter, width ceil(log2(DEBOUNCE_CYCLES+1)).
- Counter increments while the synchronised value differs from the debounced level.
- Counter clears to 0 whenever the two are equal.
- On reaching DEBOUNCE_CYCLES the level flips and the counter clears.
REQ-013 Level latency SHALL be exactly DEBOUNCE_CYCLES+2 cycles from the first clk edge that samples a new stable raw value.
REQ-014 A raw glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on any output.
REQ-015 btn_pulse[i] SHALL be high for exactly one cycle, in the same cycle btn_level[i] rises.
- No pulse is generated on a fall of btn_level.
REQ-016 Each button channel SHALL run the FSM IDLE -> HELD -> REPEAT:
- IDLE -> HELD on a level rise (press pulse issued).
- HELD -> REPEAT after REPEAT_DELAY cycles.
- REPEAT issues a pulse every REPEAT_RATE cycles.
- Any state -> IDLE on a level fall.
REQ-017 A release in the same cycle that a repeat pulse would fire SHALL suppress that pulse and return the channel to IDLE.
REQ-018 Repeat counter width SHALL be ceil(log2(max(REPEAT_DELAY,REPEAT_RATE)+1)).
- Counting saturates; it never wraps.
REQ-019 btn[0] (stamp) SHALL never auto-repeat; it stays in HELD until release.
REQ-020 Channels SHALL be fully independent; simultaneous presses yield simultaneous pulses.
REQ-021 sw_ok SHALL use the same debounce as buttons, with no pulse or repeat logic.

Reset
REQ-022 While reset=0 at a clk edge, the following SHALL be cleared to 0 at that edge:
- synchronisers, debounce counters and repeat counters;
- btn_level, btn_pulse and sw_ok;
- all FSMs (to IDLE).
REQ-023 Reset asserted mid-press SHALL cancel any pending pulse.
- A button still held after reset release debounces afresh and produces a new press pulse after DEBOUNCE_CYCLES+2 cycles.

Configuration
REQ-024 With macro BTN_REPEAT_EN defined, REQ-016 through REQ-018 SHALL apply to btn[4:1].
REQ-025 Without BTN_REPEAT_EN, every button SHALL generate only the single press pulse, and the REPEAT state and repeat counters SHALL not be synthesised.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-026 Scenario 1: raw btn[1] rises at cycle 0 and is held -> btn_level[1] rises at cycle 6 and btn_pulse[1] is high for cycle 6 only; other outputs stay 0.
REQ-027 Scenario 2: btn[2] high for 3 cycles, then low -> btn_level and btn_pulse remain 0 throughout.
REQ-028 Scenario 3 (BTN_REPEAT_EN): btn[4] held 60 cycles from cycle 0 -> pulses at cycles 6, 26, 34, 42, 50, 58; no further pulses after release.
REQ-029 Scenario 4: btn[0] held 60 cycles -> a single pulse at cycle 6 only, both with and without BTN_REPEAT_EN.
REQ-030 Scenario 5: btn[3] held, reset=0 at cycle 10 for 2 cycles -> all outputs 0 from cycle 11; the next pulse occurs 6 cycles after reset returns high.
REQ-031 Scenario 6: sw=8'hA5 applied at cycle 0 -> sw_ok=8'hA5 from cycle 6; btn_pulse stays 0.
